// File: rtl/pht_sat_tab.sv
// pht_sat_tab: multi-set pattern history table of saturating counters with a
// 2-stage read-modify-write update pipe and a sequential clear engine.
// Optional define PHT_BYPASS_EN: forward the in-flight update into the lookup path.
module pht_sat_tab #(
    parameter int SET_NUM   = 4,
    parameter int TAB_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int INIT_VAL  = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rd_en,
    input  logic [$clog2(SET_NUM)-1:0]   rd_set,
    input  logic [$clog2(TAB_DEPTH)-1:0] rd_idx,
    output logic                         rd_vld,
    output logic [CNT_W-1:0]             rd_cnt,
    output logic                         rd_taken,
    input  logic                         up_en,
    input  logic [$clog2(SET_NUM)-1:0]   up_set,
    input  logic [$clog2(TAB_DEPTH)-1:0] up_idx,
    input  logic                         up_taken,
    input  logic                         clr_req,
    output logic                         busy
);

    localparam int SW      = $clog2(SET_NUM);
    localparam int IW      = $clog2(TAB_DEPTH);
    localparam int AW      = SW + IW;
    localparam int ENTRIES = SET_NUM * TAB_DEPTH;

    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam logic [CNT_W-1:0] INIT_CNT = CNT_W'(INIT_VAL);
    localparam logic [AW-1:0]    LAST_PTR = AW'(ENTRIES - 1);

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_t;

    state_t state, state_nxt;

    logic [CNT_W-1:0] cnt_mem [ENTRIES];

    logic [AW-1:0]    rd_addr, up_addr;
    logic [AW-1:0]    clr_ptr;
    logic             idle, clr_start, clr_wr, clr_last;
    logic             up_acc, rd_acc, u2_wr;

    logic             u2_vld, u2_taken;
    logic [AW-1:0]    u2_addr;
    logic [CNT_W-1:0] u2_cnt, u2_nxt;
    logic [CNT_W-1:0] up_cur, rd_cur;

    assign rd_addr  = {rd_set, rd_idx};
    assign up_addr  = {up_set, up_idx};
    assign rd_taken = rd_cnt[CNT_W-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idle      = 1'b0;
        busy      = 1'b0;
        clr_start = 1'b0;
        clr_wr    = 1'b0;
        clr_last  = 1'b0;
        case (state)
            ST_IDLE: begin
                idle      = 1'b1;
                clr_start = clr_req;
                if (clr_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                busy     = 1'b1;
                clr_wr   = 1'b1;
                clr_last = (clr_ptr == LAST_PTR);
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // An update presented together with clr_req is dropped; the U2 write of
    // that cycle is also discarded since the clear rewrites the whole table.
    always_comb begin
        up_acc = idle && up_en && !clr_req;
        rd_acc = idle && rd_en;
        u2_wr  = u2_vld && !clr_start;
    end

    always_comb begin
        u2_nxt = u2_cnt;
        if (u2_taken) begin
            if (u2_cnt != CMAX) begin
                u2_nxt = u2_cnt + CNT_W'(1);
            end
        end else begin
            if (u2_cnt != '0) begin
                u2_nxt = u2_cnt - CNT_W'(1);
            end
        end
    end

    // Back-to-back updates to one entry must see U2's result, not the stale array.
    always_comb begin
        up_cur = cnt_mem[up_addr];
        if (u2_vld && (u2_addr == up_addr)) begin
            up_cur = u2_nxt;
        end
    end

    always_comb begin
        rd_cur = cnt_mem[rd_addr];
`ifdef PHT_BYPASS_EN
        if (u2_vld && (u2_addr == rd_addr)) begin
            rd_cur = u2_nxt;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            u2_vld   <= 1'b0;
            u2_taken <= 1'b0;
            u2_addr  <= '0;
            u2_cnt   <= '0;
        end else begin
            u2_vld <= up_acc;
            if (up_acc) begin
                u2_taken <= up_taken;
                u2_addr  <= up_addr;
                u2_cnt   <= up_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clr_ptr <= '0;
        end else if (clr_wr) begin
            clr_ptr <= clr_last ? '0 : clr_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld <= 1'b0;
            rd_cnt <= '0;
        end else begin
            rd_vld <= rd_acc;
            if (rd_acc) begin
                rd_cnt <= rd_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_mem[i] <= INIT_CNT;
            end
        end else if (clr_wr) begin
            cnt_mem[clr_ptr] <= INIT_CNT;
        end else if (u2_wr) begin
            cnt_mem[u2_addr] <= u2_nxt;
        end
    end

endmodule
